// File: rtl/exhaustive_stim_checker.sv
// ---------------------------------------------------------------------------
// exhaustive_stim_checker
//
// Stimulus-and-check engine for a small combinational netlist with N_IN
// inputs and a single output. A run walks every input vector in ascending
// binary order. Each vector is held for SETTLE cycles, then checked for one
// cycle against a reduction function of the vector (AND, OR, XOR or NAND)
// that is chosen at start. The engine reports the number of mismatching
// vectors, the first failing vector and an overall pass flag.
//
// Parameters
//   N_IN    number of DUT inputs (1..16)
//   SETTLE  cycles a vector is held before it is sampled (>= 1)
//
// Ports
//   i_clk               single clock, all state on the rising edge
//   i_reset             synchronous active-high reset, clears all state
//   i_start             begin a run (only honoured in IDLE or DONE)
//   i_mode[1:0]         expected function: 0 AND, 1 OR, 2 XOR, 3 NAND
//   o_stim[N_IN-1:0]    vector driven onto the DUT inputs
//   i_dut_out           DUT output being checked
//   o_busy              run in progress
//   o_done              run complete, held until next start or reset
//   o_pass              valid while done, 1 when no vector mismatched
//   o_err_count[N_IN:0] number of mismatching vectors
//   o_first_fail_valid  at least one mismatch recorded this run
//   o_first_fail_vec    stimulus value of the first mismatch
// ---------------------------------------------------------------------------
module exhaustive_stim_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [1:0]      i_mode,
  output logic [N_IN-1:0] o_stim,
  input  logic            i_dut_out,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_count,
  output logic            o_first_fail_valid,
  output logic [N_IN-1:0] o_first_fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The settle counter only has to reach SETTLE-1, so it is sized for that.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] STIM_LAST   = '1;
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [N_IN-1:0] STIM_ONE    = N_IN'(1);

  state_t            r_state;
  logic [N_IN-1:0]   r_stim;
  logic [CW-1:0]     r_settleCnt;
  logic [1:0]        r_mode;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [N_IN:0]     r_errCount;
  logic              r_ffValid;
  logic [N_IN-1:0]   r_ffVec;

  state_t            w_state;
  logic [N_IN-1:0]   w_stim;
  logic [CW-1:0]     w_settleCnt;
  logic [1:0]        w_mode;
  logic              w_busy;
  logic              w_done;
  logic              w_pass;
  logic [N_IN:0]     w_errCount;
  logic              w_ffValid;
  logic [N_IN-1:0]   w_ffVec;

  logic              w_expected;
  logic              w_mismatch;
  logic [N_IN:0]     w_errInc;

  // Expected DUT output for the vector currently on o_stim, using the mode
  // captured when the run started so later mode changes cannot disturb it.
  always_comb begin
    w_expected = 1'b0;
    case (r_mode)
      2'd0:    w_expected = &r_stim;
      2'd1:    w_expected = |r_stim;
      2'd2:    w_expected = ^r_stim;
      default: w_expected = ~(&r_stim);
    endcase
  end

  // The incremented count is used both to update err_count and to decide
  // pass on the final vector, so the last vector's own result is included.
  always_comb begin
    w_mismatch = (i_dut_out != w_expected);
    w_errInc   = r_errCount + {{N_IN{1'b0}}, w_mismatch};
  end

  // Next-state and next-value logic. Everything holds by default; only the
  // state-specific branches below move anything.
  always_comb begin
    w_state     = r_state;
    w_stim      = r_stim;
    w_settleCnt = r_settleCnt;
    w_mode      = r_mode;
    w_busy      = r_busy;
    w_done      = r_done;
    w_pass      = r_pass;
    w_errCount  = r_errCount;
    w_ffValid   = r_ffValid;
    w_ffVec     = r_ffVec;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state     = ST_SETTLE;
          w_stim      = '0;
          w_settleCnt = '0;
          w_mode      = i_mode;
          w_busy      = 1'b1;
          w_done      = 1'b0;
          w_pass      = 1'b0;
          w_errCount  = '0;
          w_ffValid   = 1'b0;
          w_ffVec     = '0;
        end
      end

      ST_SETTLE: begin
        w_settleCnt = r_settleCnt + CNT_ONE;
        if (r_settleCnt == SETTLE_LAST) begin
          w_state = ST_CHECK;
        end
      end

      ST_CHECK: begin
        w_errCount = w_errInc;
        if (w_mismatch && !r_ffValid) begin
          w_ffValid = 1'b1;
          w_ffVec   = r_stim;
        end
        if (r_stim == STIM_LAST) begin
          w_state = ST_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = (w_errInc == '0);
        end else begin
          w_state     = ST_SETTLE;
          w_stim      = r_stim + STIM_ONE;
          w_settleCnt = '0;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // State register. Reset takes priority over everything, including a start
  // arriving in the same cycle, and abandons any run in progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_stim      <= '0;
      r_settleCnt <= '0;
      r_mode      <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_errCount  <= '0;
      r_ffValid   <= 1'b0;
      r_ffVec     <= '0;
    end else begin
      r_state     <= w_state;
      r_stim      <= w_stim;
      r_settleCnt <= w_settleCnt;
      r_mode      <= w_mode;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_pass      <= w_pass;
      r_errCount  <= w_errCount;
      r_ffValid   <= w_ffValid;
      r_ffVec     <= w_ffVec;
    end
  end

  assign o_stim             = r_stim;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_pass             = r_pass;
  assign o_err_count        = r_errCount;
  assign o_first_fail_valid = r_ffValid;
  assign o_first_fail_vec   = r_ffVec;

endmodule

// File: doc/exhaustive_stim_checker.md
# exhaustive_stim_checker

Parametrised, synthesizable stimulus-and-check engine for small combinational netlists such as the two-input HelloWorld gate, generalised to N inputs. It walks every input vector in ascending binary order, waits a settle window, and samples the single DUT output. Each sample is compared against a run-time-selected reduction function, and the engine reports mismatch count, first failing vector and pass/fail. It sits beside the DUT in the test harness and replaces hand-written initial-block stimulus.

## Interface
- N_IN, 2, number of DUT inputs (1..16)
- SETTLE, 2, cycles a vector is held before sampling (>= 1)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  begin a run; sampled only in IDLE or DONE
- mode  in  2  expected function, latched at start: 0 AND, 1 OR, 2 XOR, 3 NAND (reductions over stim)
- stim  out  N_IN  vector driven to DUT inputs (bit 0 = first DUT input)
- dut_out  in  1  DUT output being checked
- busy  out  1  run in progress
- done  out  1  run complete; held until next start or reset
- pass  out  1  valid while done; 1 iff err_count == 0
- err_count  out  N_IN+1  number of mismatching vectors
- first_fail_valid  out  1  at least one mismatch recorded this run
- first_fail_vec  out  N_IN  stim value of first mismatch

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start: stim<=0, settle counter<=0, err_count<=0, first_fail_valid<=0, first_fail_vec<=0, done<=0, pass<=0, mode latched, busy<=1, -> SETTLE.
- SETTLE: counter increments each cycle; after exactly SETTLE cycles in SETTLE, -> CHECK. stim constant.
- CHECK (1 cycle): expected = f(mode_latched, stim); on that edge, if dut_out != expected: err_count+1; if first_fail_valid==0, first_fail_vec<=stim and first_fail_valid<=1.
  - If stim == all-ones: -> DONE, busy<=0, done<=1, pass<=(final err_count==0), using the updated count including this vector.
  - Else: stim<=stim+1, counter<=0, -> SETTLE.
- err_count cannot overflow: max 2^N_IN fits in N_IN+1 bits; no saturation logic.
- start while busy: ignored, no effect on run or latched mode.
- mode changes mid-run: ignored.
- DONE: stim holds last vector (all-ones), results held stable.
- reset at any time, including mid-run: next edge all outputs to reset values, state IDLE; run is lost, not resumed.
- reset and start in the same cycle: reset wins.

## Timing
- Reset values: stim 0, busy 0, done 0, pass 0, err_count 0, first_fail_valid 0, first_fail_vec 0.
- Start accepted at edge E0: busy=1 and stim=0 visible after E0.
- Each vector occupies SETTLE+1 cycles. dut_out is sampled at the edge ending the CHECK cycle, i.e. SETTLE+1 cycles after stim changed.
- done=1 and busy=0 visible after edge E0 + 2^N_IN*(SETTLE+1). Example: N_IN=2, SETTLE=2 gives 12 cycles.
- No combinational path from inputs to outputs; all outputs registered.

## Test plan
- N_IN=2, SETTLE=2, mode 0, DUT = a AND b. Pulse start. Required: stim sequence 0,1,2,3, each held 3 cycles; done exactly 12 cycles after the start edge; pass=1, err_count=0, first_fail_valid=0.
- Same setup, mode 1 (OR), DUT stuck-at-0. Required: err_count=3, first_fail_vec=2'b01, first_fail_valid=1, pass=0.
- Mode 2 (XOR), DUT = OR. Required: err_count=1, first_fail_vec=2'b11, pass=0. Then mode 3 (NAND), DUT = NAND, restart from DONE. Required: previous results cleared on the start edge; final pass=1, err_count=0.
- Start pulsed again at cycle 5 of a run, and mode changed mid-run. Required: no restart; stim progression and done time unchanged; result matches the mode latched at the original start.
- reset asserted at cycle 7 of a run, with start held high in the same cycle. Required: after that edge all outputs are 0 and state is IDLE. Start 3 cycles later runs a fresh full 12-cycle sequence from stim=0.
- N_IN=3, SETTLE=1, mode 2, DUT = 3-input XOR. Required: 8 vectors of 2 cycles each; done 16 cycles after start; err_count=4'd0, pass=1.
